// File: rtl/video_timing_generator.sv
// Parametrised video timing generator: raster counters, sync/DE/HDMI control
// decode, active-area coordinates, frame/line strobes and four test patterns.
// All outputs are registered from the counter position of the previous
// enabled cycle, so they stay mutually aligned. enable=0 freezes all state.
module video_timing_generator #(
  parameter int H_ACTIVE       = 640,
  parameter int H_BLANK        = 160,
  parameter int HSYNC_START    = 16,
  parameter int HSYNC_LEN      = 96,
  parameter int V_ACTIVE       = 480,
  parameter int V_BLANK        = 45,
  parameter int V_ACTIVE_START = 45,
  parameter int VSYNC_START    = 10,
  parameter int VSYNC_LEN      = 2,
  parameter bit HSYNC_POL      = 1'b0,
  parameter bit VSYNC_POL      = 1'b0,
  parameter int PREAMBLE_LEN   = 8,
  parameter int GUARD_LEN      = 2,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    pattern_sel,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [3:0]    ctl,
  output logic          video_guard,
  output logic [7:0]    pixel_data_0,
  output logic [7:0]    pixel_data_1,
  output logic [7:0]    pixel_data_2,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [23:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GS      = H_BLANK - GUARD_LEN;   // guard band start
  localparam int PS      = GS - PREAMBLE_LEN;     // preamble start
  localparam int BAR_W   = H_ACTIVE / 8;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [23:0]   fc;       // completed frames
  logic [1:0]    pat;      // pattern in force for the current frame

  // Position as plain 32-bit values so all comparisons run at one width
  logic [31:0] hc, vc, xa, ya, bar_q;
  logic        h_wrap, v_wrap;

  assign hc     = 32'(hcnt);
  assign vc     = 32'(vcnt);
  assign xa     = hc - 32'(H_BLANK);
  assign ya     = vc - 32'(V_ACTIVE_START);
  assign bar_q  = xa / 32'(BAR_W);
  assign h_wrap = (hc == H_TOTAL - 1);
  assign v_wrap = (vc == V_TOTAL - 1);

  // Only the low bits of these helpers feed outputs
  logic unused_bits;
  assign unused_bits = ^{ya, bar_q};

  logic          n_line_act, n_de, n_hsync, n_vsync, n_vg;
  logic [3:0]    n_ctl;
  logic [XW-1:0] n_x;
  logic [YW-1:0] n_y;
  logic [23:0]   n_pix;    // {red, green, blue}
  logic [2:0]    bar;

  // Raster counters, frame counter and per-frame pattern latch
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      fc   <= '0;
      pat  <= '0;
    end else if (enable) begin
      if (h_wrap) begin
        hcnt <= '0;
        if (v_wrap) begin
          vcnt <= '0;
          fc   <= fc + 24'd1;
          pat  <= pattern_sel;
        end else begin
          vcnt <= vcnt + VW'(1);
        end
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  // Decode the next output values from the current counter position
  always_comb begin
    n_line_act = (vc >= V_ACTIVE_START) && (vc < V_ACTIVE_START + V_ACTIVE);
    n_de       = (hc >= H_BLANK) && n_line_act;
    n_hsync    = ((hc >= HSYNC_START) && (hc < HSYNC_START + HSYNC_LEN)) ? HSYNC_POL : ~HSYNC_POL;
    n_vsync    = ((vc >= VSYNC_START) && (vc < VSYNC_START + VSYNC_LEN)) ? VSYNC_POL : ~VSYNC_POL;
    n_ctl      = 4'b0000;
    n_vg       = 1'b0;
    if (n_line_act) begin
      if ((hc >= PS) && (hc < GS)) begin
        n_ctl = 4'b0001;
      end else if ((hc >= GS) && (hc < H_BLANK)) begin
        n_ctl = 4'b1101;
        n_vg  = 1'b1;
      end
    end
    n_x   = n_de ? xa[XW-1:0] : '0;
    n_y   = n_de ? ya[YW-1:0] : '0;
    bar   = bar_q[2:0];
    n_pix = 24'h000000;
    if (n_de) begin
      case (pat)
        2'd0: begin
          case (bar)
            3'd0:    n_pix = 24'hFFFFFF;  // white
            3'd1:    n_pix = 24'hFFFF00;  // yellow
            3'd2:    n_pix = 24'h00FFFF;  // cyan
            3'd3:    n_pix = 24'h00FF00;  // green
            3'd4:    n_pix = 24'hFF00FF;  // magenta
            3'd5:    n_pix = 24'hFF0000;  // red
            3'd6:    n_pix = 24'h0000FF;  // blue
            default: n_pix = 24'h000000;  // black
          endcase
        end
        2'd1: begin
          if (xa * 3 < H_ACTIVE)          n_pix = {fc[23:16], fc[15:8], fc[7:0]};
          else if (xa * 3 < 2 * H_ACTIVE) n_pix = {fc[23:16], fc[7:0], fc[15:8]};
          else                            n_pix = {fc[7:0], fc[23:16], fc[15:8]};
        end
        2'd2:    n_pix = fc;
        default: n_pix = (xa[3] ^ ya[3]) ? 24'hFFFFFF : 24'h000000;
      endcase
    end
  end

  // Output registers: one-cycle latency, held while enable is low
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      de           <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      ctl          <= 4'b0000;
      video_guard  <= 1'b0;
      pixel_data_0 <= 8'h00;
      pixel_data_1 <= 8'h00;
      pixel_data_2 <= 8'h00;
      x            <= '0;
      y            <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_cnt    <= 24'h000000;
    end else if (enable) begin
      de           <= n_de;
      hsync        <= n_hsync;
      vsync        <= n_vsync;
      ctl          <= n_ctl;
      video_guard  <= n_vg;
      pixel_data_2 <= n_pix[23:16];
      pixel_data_1 <= n_pix[15:8];
      pixel_data_0 <= n_pix[7:0];
      x            <= n_x;
      y            <= n_y;
      line_start   <= (hc == 0);
      frame_start  <= (hc == 0) && (vc == 0);
      frame_cnt    <= fc;
    end
  end

endmodule
